// File: rtl/cap_axis_checker.sv
// AXI4-Stream video sink: checks frame geometry and an optional counting pattern, with optional
// LFSR backpressure. It reports per-beat pulses, sticky error flags and saturating counters.
//
// state    | meaning
// WAIT_SOF | idle between frames, beats without tuser are dropped
// ACTIVE   | inside a frame, every accepted beat is a pixel at (x,y)
// SKIP_EOL | line overran H_ACTIVE, dropping beats until tlast
module cap_axis_checker #(
  parameter int DATA_W    = 16,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int PAT_CHECK = 1,
  parameter int THROTTLE  = 0,
  parameter int CNT_W     = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              frame_done,
  output logic              err_pulse,
  output logic [3:0]        err_flags,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    SKIP_EOL = 2'd2
  } state_t;

  state_t             state_q, state_d, cur_st;
  logic [XW-1:0]      x_q, x_d, cur_x;
  logic [YW-1:0]      y_q, y_d, cur_y;
  logic [DATA_W-1:0]  exp_q, exp_d, cur_exp;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               tready_q, tready_d;
  logic               frame_done_q, frame_done_d;
  logic               err_pulse_q, err_pulse_d;
  logic [3:0]         err_flags_q, err_flags_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic accept, line_end, fdone;
  logic e_data, e_sof, e_late, e_early, err_any;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    exp_d    = exp_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tready_d = (THROTTLE != 0) ? (lfsr_d[0] | lfsr_d[1]) : 1'b1;
    accept   = s_axis_tvalid & tready_q;
    cur_st   = state_q;
    cur_x    = x_q;
    cur_y    = y_q;
    cur_exp  = exp_q;
    e_data   = 1'b0;
    e_sof    = 1'b0;
    e_late   = 1'b0;
    e_early  = 1'b0;
    line_end = 1'b0;
    fdone    = 1'b0;

    if (accept) begin
      // A SOF always restarts the frame at (0,0); tlast on the same beat is then judged at x=0.
      if (s_axis_tuser) begin
        e_sof   = (state_q != WAIT_SOF);
        cur_st  = ACTIVE;
        cur_x   = '0;
        cur_y   = '0;
        cur_exp = '0;
      end

      case (cur_st)
        ACTIVE: begin
          e_data  = (PAT_CHECK != 0) && (s_axis_tdata != cur_exp);
          exp_d   = cur_exp + DATA_W'(1);
          state_d = ACTIVE;
          y_d     = cur_y;
          if (s_axis_tlast) begin
            e_early  = (cur_x != X_LAST);
            line_end = 1'b1;
          end else if (cur_x == X_LAST) begin
            e_late  = 1'b1;
            state_d = SKIP_EOL;
          end else begin
            x_d = cur_x + XW'(1);
          end
        end
        SKIP_EOL: begin
          // Overrun beats are not pixels: no pattern check, expected value holds.
          if (s_axis_tlast) line_end = 1'b1;
        end
        default: ;
      endcase

      // A short final line still closes the frame, so a bad frame is counted too.
      if (line_end) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          fdone   = 1'b1;
          state_d = WAIT_SOF;
          y_d     = '0;
        end else begin
          state_d = ACTIVE;
          y_d     = cur_y + YW'(1);
        end
      end
    end

    err_any      = e_data | e_sof | e_late | e_early;
    err_pulse_d  = err_any;
    frame_done_d = fdone;

    if (clr) begin
      err_flags_d = '0;
      err_cnt_d   = '0;
      frame_cnt_d = '0;
    end else begin
      err_flags_d = err_flags_q | {e_data, e_sof, e_late, e_early};
      err_cnt_d   = (err_any && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
      frame_cnt_d = (fdone && (frame_cnt_q != '1)) ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SOF;
      x_q          <= '0;
      y_q          <= '0;
      exp_q        <= '0;
      lfsr_q       <= 16'hACE1;
      tready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_flags_q  <= '0;
      err_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      exp_q        <= exp_d;
      lfsr_q       <= lfsr_d;
      tready_q     <= tready_d;
      frame_done_q <= frame_done_d;
      err_pulse_q  <= err_pulse_d;
      err_flags_q  <= err_flags_d;
      err_cnt_q    <= err_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign frame_done    = frame_done_q;
  assign err_pulse     = err_pulse_q;
  assign err_flags     = err_flags_q;
  assign err_cnt       = err_cnt_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_cap_axis_checker.sv
// Directed bench for cap_axis_checker: 8x4 frames on an unthrottled instance (4-bit counters)
// and a throttled instance for backpressure and duty.
module tb_cap_axis_checker;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic        tready, frame_done, err_pulse;
  logic [3:0]  err_flags, err_cnt, frame_cnt;

  logic [15:0] t_data = '0;
  logic        t_valid = 1'b0, t_user = 1'b0, t_last = 1'b0;
  logic        t_ready, t_frame_done, t_err_pulse;
  logic [3:0]  t_err_flags;
  logic [15:0] t_err_cnt, t_frame_cnt;

  int total = 0;
  int bad = 0;

  always #5 pclk = ~pclk;

  cap_axis_checker #(.DATA_W(16), .H_ACTIVE(8), .V_ACTIVE(4), .PAT_CHECK(1), .THROTTLE(0), .CNT_W(4)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .clr(clr),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .s_axis_tready(tready), .frame_done(frame_done), .err_pulse(err_pulse),
    .err_flags(err_flags), .err_cnt(err_cnt), .frame_cnt(frame_cnt));

  cap_axis_checker #(.DATA_W(16), .H_ACTIVE(8), .V_ACTIVE(4), .PAT_CHECK(1), .THROTTLE(1), .CNT_W(16)) u_thr (
    .pclk(pclk), .rst_n(rst_n), .clr(1'b0),
    .s_axis_tdata(t_data), .s_axis_tvalid(t_valid), .s_axis_tuser(t_user), .s_axis_tlast(t_last),
    .s_axis_tready(t_ready), .frame_done(t_frame_done), .err_pulse(t_err_pulse),
    .err_flags(t_err_flags), .err_cnt(t_err_cnt), .frame_cnt(t_frame_cnt));

  typedef struct {
    logic [15:0] d;
    logic        u;
    logic        l;
    logic        ep;
    logic        fd;
    logic [3:0]  fl;
  } vec_t;

  vec_t vq[$];

  logic meas = 1'b0;
  int   meas_cyc = 0;
  int   meas_rdy = 0;

  always @(negedge pclk) if (meas) begin
    meas_cyc++;
    if (t_ready) meas_rdy++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=no tready want=tready within bound", nm);
  endtask

  // Called just after a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic beat(input logic [15:0] d, input logic u, input logic l);
    int n = 0;
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    while (!tready && n < 50) begin @(negedge pclk); n++; end
    if (!tready) timeout("beat_tready");
    @(negedge pclk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic t_beat(input logic [15:0] d, input logic u, input logic l);
    int n = 0;
    t_data = d; t_user = u; t_last = l; t_valid = 1'b1;
    while (!t_ready && n < 200) begin @(negedge pclk); n++; end
    if (!t_ready) timeout("thr_beat_tready");
    @(negedge pclk);
    t_valid = 1'b0; t_user = 1'b0; t_last = 1'b0;
  endtask

  task automatic add(input logic [15:0] d, input logic u, input logic l,
                     input logic ep, input logic fd, input logic [3:0] fl);
    vec_t v;
    v.d = d; v.u = u; v.l = l; v.ep = ep; v.fd = fd; v.fl = fl;
    vq.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      beat(vq[i].d, vq[i].u, vq[i].l);
      chk($sformatf("%s[%0d].err_pulse", tag, i), err_pulse, vq[i].ep);
      chk($sformatf("%s[%0d].frame_done", tag, i), frame_done, vq[i].fd);
      chk($sformatf("%s[%0d].err_flags", tag, i), err_flags, vq[i].fl);
    end
    vq.delete();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge pclk);
    clr = 1'b0;
  endtask

  task automatic add_clean_frame();
    for (int k = 0; k < 32; k++)
      add(16'(k), k == 0, (k % 8) == 7, 1'b0, k == 31, 4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nfd;
    repeat (3) @(negedge pclk);
    chk("rst.tready", tready, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.err_pulse", err_pulse, 0);
    chk("rst.err_flags", err_flags, 0);
    chk("rst.err_cnt", err_cnt, 0);
    chk("rst.frame_cnt", frame_cnt, 0);
    chk("rst.thr_tready", t_ready, 0);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("post_rst.tready", tready, 1);

    // Two dropped beats in WAIT_SOF, then a clean frame.
    add(16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    add_clean_frame();
    run_vecs("clean");
    @(negedge pclk);
    chk("clean.pulse_end", frame_done, 0);
    chk("clean.frame_cnt", frame_cnt, 1);
    chk("clean.err_cnt", err_cnt, 0);

    do_clr();
    chk("clr.frame_cnt", frame_cnt, 0);

    // Early tlast at x=5 on line 1 (pixel 13); pattern keeps counting.
    for (int k = 0; k < 30; k++)
      add(16'(k), k == 0, (k == 7) || (k == 13) || (k == 21) || (k == 29),
          k == 13, k == 29, (k >= 13) ? 4'b0001 : 4'b0000);
    run_vecs("eol_early");
    chk("eol_early.err_cnt", err_cnt, 1);
    chk("eol_early.frame_cnt", frame_cnt, 1);

    do_clr();
    // No tlast at x=7 on line 2; tlast arrives three beats later on garbage data.
    for (int k = 0; k < 24; k++)
      add(16'(k), k == 0, (k == 7) || (k == 15), k == 23, 1'b0, (k == 23) ? 4'b0010 : 4'b0000);
    add(16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    add(16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
    add(16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
    for (int k = 24; k < 32; k++)
      add(16'(k), 1'b0, k == 31, 1'b0, k == 31, 4'b0010);
    run_vecs("eol_late");
    chk("eol_late.err_cnt", err_cnt, 1);
    chk("eol_late.frame_cnt", frame_cnt, 1);

    do_clr();
    // SOF at (3,2) restarts the frame.
    nfd = 0;
    for (int k = 0; k < 19; k++) begin
      beat(16'(k), k == 0, (k % 8) == 7);
      nfd += int'(frame_done);
    end
    beat(16'h0000, 1'b1, 1'b0);
    chk("sof.err_pulse", err_pulse, 1);
    chk("sof.err_flags", err_flags, 4'b0100);
    for (int k = 1; k < 32; k++) begin
      beat(16'(k), 1'b0, (k % 8) == 7);
      if (k < 31) nfd += int'(frame_done);
    end
    chk("sof.no_early_done", nfd, 0);
    chk("sof.frame_done_31", frame_done, 1);
    chk("sof.err_cnt", err_cnt, 1);
    chk("sof.frame_cnt", frame_cnt, 1);

    do_clr();
    for (int k = 0; k < 32; k++)
      add((k == 10) ? 16'hFFFF : 16'(k), k == 0, (k % 8) == 7,
          k == 10, k == 31, (k >= 10) ? 4'b1000 : 4'b0000);
    run_vecs("data");
    chk("data.err_cnt", err_cnt, 1);

    // Nineteen bad frames saturate both 4-bit counters.
    do_clr();
    for (int f = 0; f < 19; f++) begin
      for (int k = 0; k < 32; k++)
        beat((k == 10) ? 16'hFFFF : 16'(k), k == 0, (k % 8) == 7);
      if (f == 13) chk("sat.err_cnt_14", err_cnt, 14);
      if (f == 14) chk("sat.err_cnt_15", err_cnt, 15);
    end
    chk("sat.err_cnt_final", err_cnt, 15);
    chk("sat.frame_cnt_final", frame_cnt, 15);

    do_clr();
    // tuser and tlast together mid-frame: sof and eol_early on one beat, one count.
    add(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101);
    add(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
    run_vecs("sof_eol");
    chk("sof_eol.err_cnt", err_cnt, 1);

    // clr on the same cycle as an error beat wins.
    do_clr();
    clr = 1'b1;
    beat(16'h0005, 1'b1, 1'b0);
    clr = 1'b0;
    chk("clr_wins.err_cnt", err_cnt, 0);
    chk("clr_wins.err_flags", err_flags, 0);
    beat(16'h0007, 1'b0, 1'b0);
    chk("clr_after.err_cnt", err_cnt, 1);
    chk("clr_after.err_flags", err_flags, 4'b1000);

    // Reset in the middle of a line.
    beat(16'h0002, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst.tready", tready, 0);
    chk("midrst.err_flags", err_flags, 0);
    chk("midrst.err_cnt", err_cnt, 0);
    chk("midrst.err_pulse", err_pulse, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    for (int k = 2; k < 8; k++)
      add(16'(k), 1'b0, k == 7, 1'b0, 1'b0, 4'b0000);
    add_clean_frame();
    run_vecs("after_rst");
    chk("after_rst.frame_cnt", frame_cnt, 1);
    chk("after_rst.err_cnt", err_cnt, 0);

    // Throttled instance: 1000 beats with random valid gaps.
    meas = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge pclk);
      t_beat(16'(i % 32), (i % 32) == 0, (i % 8) == 7);
    end
    meas = 1'b0;
    @(negedge pclk);
    chk("thr.frame_cnt", t_frame_cnt, 31);
    chk("thr.err_cnt", t_err_cnt, 0);
    chk("thr.err_flags", t_err_flags, 0);
    total++;
    if (meas_rdy * 100 < meas_cyc * 70 || meas_rdy * 100 > meas_cyc * 80) begin
      bad++;
      $display("FAIL thr.duty: got=%0d/%0d ready cycles want=70-80%%", meas_rdy, meas_cyc);
    end

    // Mid-line reset on the throttled instance, then dropped beats until a fresh SOF.
    t_beat(16'h0008, 1'b0, 1'b0);
    t_beat(16'h0009, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("thr_rst.tready", t_ready, 0);
    chk("thr_rst.frame_cnt", t_frame_cnt, 0);
    chk("thr_rst.frame_done", t_frame_done, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    t_beat(16'h000A, 1'b0, 1'b0);
    t_beat(16'h000B, 1'b0, 1'b1);
    chk("thr_rst.dropped", t_err_cnt, 0);
    for (int k = 0; k < 32; k++)
      t_beat(16'(k), k == 0, (k % 8) == 7);
    @(negedge pclk);
    chk("thr_rst.frame_cnt_after", t_frame_cnt, 1);
    chk("thr_rst.err_cnt_after", t_err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
